// File: rtl/pipeline_sequencer.sv
// -----------------------------------------------------------------------------
// pipeline_sequencer
//
// Run-control block for the N-stage MIPS pipeline. It loads the program into
// instruction memory, runs it either free-running or one cycle per step
// request, honours the debug freeze, spreads hazard stalls/bubbles and branch
// flushes over the stage registers, and drains the pipeline once a HALT
// opcode reaches ID.
//
// Ports
//   i_clk, i_reset      clock, synchronous active-high reset
//   i_start             IDLE -> RUN/STEP_WAIT, DONE -> IDLE
//   i_step_mode         sampled with an accepted start (1 = single-step)
//   i_step              single-step advance request
//   i_halt              debug freeze (level)
//   i_halt_detected     HALT opcode present in ID
//   i_hazard_stall      load-use stall from the hazard unit
//   i_branch_flush      taken branch/jump resolved in ID
//   i_load_*            program-load write port (accepted in IDLE only)
//   o_stage_enable      per-stage register enable (combinational)
//   o_stage_flush       per-stage bubble insert (combinational)
//   o_imem_*            registered instruction-memory write port
//   o_state             current state encoding
//   o_cycle_count       saturating count of advanced cycles
//   o_done              program finished
//   o_timeout           watchdog fired (only with PIPE_SEQ_WATCHDOG_EN)
//
// Optional feature: define PIPE_SEQ_WATCHDOG_EN to add the MAX_CYCLES
// watchdog and its o_timeout output.
// -----------------------------------------------------------------------------
module pipeline_sequencer #(
  parameter int NB_STAGES   = 5,
  parameter int NB_ADDR     = 32,
  parameter int NB_DATA     = 32,
  parameter int NB_CYCLES   = 32,
  parameter int STALL_DEPTH = 2,
  parameter int MAX_CYCLES  = 1000000
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_start,
  input  logic                 i_step_mode,
  input  logic                 i_step,
  input  logic                 i_halt,
  input  logic                 i_halt_detected,
  input  logic                 i_hazard_stall,
  input  logic                 i_branch_flush,
  input  logic                 i_load_valid,
  input  logic [NB_ADDR-1:0]   i_load_addr,
  input  logic [NB_DATA-1:0]   i_load_data,
  output logic [NB_STAGES-1:0] o_stage_enable,
  output logic [NB_STAGES-1:0] o_stage_flush,
  output logic                 o_imem_we,
  output logic [NB_ADDR-1:0]   o_imem_addr,
  output logic [NB_DATA-1:0]   o_imem_data,
  output logic [2:0]           o_state,
  output logic [NB_CYCLES-1:0] o_cycle_count,
`ifdef PIPE_SEQ_WATCHDOG_EN
  output logic                 o_timeout,
`endif
  output logic                 o_done
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RUN       = 3'd1,
    ST_STEP_WAIT = 3'd2,
    ST_STEP_EXEC = 3'd3,
    ST_DRAIN     = 3'd4,
    ST_DONE      = 3'd5
  } state_t;

  // Drain counter must hold NB_STAGES-1.
  localparam int DRAIN_W = $clog2(NB_STAGES) + 1;
  localparam logic [DRAIN_W-1:0] DRAIN_INIT = DRAIN_W'(NB_STAGES - 1);
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(1);

  state_t               state_q, state_d;
  logic [NB_CYCLES-1:0] cycle_cnt_q, cycle_cnt_d;
  logic [DRAIN_W-1:0]   drain_cnt_q, drain_cnt_d;
  logic                 done_q, done_d;
  logic                 imem_we_q, imem_we_d;
  logic [NB_ADDR-1:0]   imem_addr_q, imem_addr_d;
  logic [NB_DATA-1:0]   imem_data_q, imem_data_d;
  logic                 advance;
  logic                 halt_to_drain;
  logic [NB_STAGES-1:0] stage_enable;
  logic [NB_STAGES-1:0] stage_flush;

`ifdef PIPE_SEQ_WATCHDOG_EN
  localparam logic [NB_CYCLES-1:0] WD_LIMIT = NB_CYCLES'(MAX_CYCLES);
  logic timeout_q, timeout_d;
`endif

  // The pipeline moves only in RUN, STEP_EXEC and DRAIN, and never while
  // the debug freeze is held.
  assign advance = ((state_q == ST_RUN) || (state_q == ST_STEP_EXEC) ||
                    (state_q == ST_DRAIN)) && !i_halt;

  // A stalled cycle keeps the HALT instruction in ID, so the halt is only
  // acted upon on an unstalled cycle.
  assign halt_to_drain = i_halt_detected && !i_hazard_stall;

  // Stage enable/flush distribution. Stall wins over branch flush; the drain
  // modifier is layered on top so IF stays frozen and ID receives bubbles
  // while the remaining instructions retire.
  always_comb begin : stage_ctrl
    stage_enable = '0;
    stage_flush  = '0;
    if (advance) begin
      stage_enable = '1;
      if (i_hazard_stall) begin
        for (int i = 0; i < STALL_DEPTH; i++) begin
          stage_enable[i] = 1'b0;
        end
        stage_flush[STALL_DEPTH] = 1'b1;
      end else if (i_branch_flush) begin
        stage_flush[1] = 1'b1;
      end
      if (state_q == ST_DRAIN) begin
        stage_enable[0] = 1'b0;
        stage_flush[1]  = 1'b1;
      end
    end else if ((state_q == ST_DONE) && i_start && !i_halt) begin
      // Leaving DONE clears every stage register so the next run starts clean.
      stage_flush = '1;
    end
  end

  // Next-state, counters and program-load capture.
  always_comb begin : next_state
    state_d     = state_q;
    cycle_cnt_d = cycle_cnt_q;
    drain_cnt_d = drain_cnt_q;
    done_d      = done_q;
    imem_we_d   = 1'b0;
    imem_addr_d = imem_addr_q;
    imem_data_d = imem_data_q;
`ifdef PIPE_SEQ_WATCHDOG_EN
    timeout_d   = timeout_q;
`endif

    // Program load is independent of the freeze but only legal in IDLE.
    if ((state_q == ST_IDLE) && i_load_valid) begin
      imem_we_d   = 1'b1;
      imem_addr_d = i_load_addr;
      imem_data_d = i_load_data;
    end

    if (advance && (cycle_cnt_q != '1)) begin
      cycle_cnt_d = cycle_cnt_q + NB_CYCLES'(1);
    end

    if (!i_halt) begin
      case (state_q)
        ST_IDLE: begin
          if (i_start) begin
            state_d     = i_step_mode ? ST_STEP_WAIT : ST_RUN;
            cycle_cnt_d = '0;
          end
        end
        ST_RUN: begin
          if (halt_to_drain) begin
            state_d     = ST_DRAIN;
            drain_cnt_d = DRAIN_INIT;
          end
        end
        ST_STEP_WAIT: begin
          if (i_step) begin
            state_d = ST_STEP_EXEC;
          end
        end
        ST_STEP_EXEC: begin
          if (halt_to_drain) begin
            state_d     = ST_DRAIN;
            drain_cnt_d = DRAIN_INIT;
          end else begin
            state_d = ST_STEP_WAIT;
          end
        end
        ST_DRAIN: begin
          if (drain_cnt_q == DRAIN_LAST) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            drain_cnt_d = drain_cnt_q - DRAIN_W'(1);
          end
        end
        ST_DONE: begin
          if (i_start) begin
            state_d = ST_IDLE;
            done_d  = 1'b0;
`ifdef PIPE_SEQ_WATCHDOG_EN
            timeout_d = 1'b0;
`endif
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

`ifdef PIPE_SEQ_WATCHDOG_EN
    // A runaway program is forced into the normal drain sequence so the
    // pipeline still ends in a clean DONE state.
    if (!i_halt && (cycle_cnt_q >= WD_LIMIT) &&
        ((state_q == ST_RUN) || (state_q == ST_STEP_WAIT) ||
         (state_q == ST_STEP_EXEC))) begin
      state_d     = ST_DRAIN;
      drain_cnt_d = DRAIN_INIT;
      timeout_d   = 1'b1;
    end
`endif
  end

  // State and output registers; reset also cancels any pending load write.
  always_ff @(posedge i_clk) begin : state_reg
    if (i_reset) begin
      state_q     <= ST_IDLE;
      cycle_cnt_q <= '0;
      drain_cnt_q <= '0;
      done_q      <= 1'b0;
      imem_we_q   <= 1'b0;
      imem_addr_q <= '0;
      imem_data_q <= '0;
`ifdef PIPE_SEQ_WATCHDOG_EN
      timeout_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cycle_cnt_q <= cycle_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      done_q      <= done_d;
      imem_we_q   <= imem_we_d;
      imem_addr_q <= imem_addr_d;
      imem_data_q <= imem_data_d;
`ifdef PIPE_SEQ_WATCHDOG_EN
      timeout_q   <= timeout_d;
`endif
    end
  end

  assign o_stage_enable = stage_enable;
  assign o_stage_flush  = stage_flush;
  assign o_imem_we      = imem_we_q;
  assign o_imem_addr    = imem_addr_q;
  assign o_imem_data    = imem_data_q;
  assign o_state        = state_q;
  assign o_cycle_count  = cycle_cnt_q;
  assign o_done         = done_q;
`ifdef PIPE_SEQ_WATCHDOG_EN
  assign o_timeout      = timeout_q;
`endif

endmodule

// File: tb/tb_pipeline_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pipeline_sequencer
//
// Directed scenarios followed by a randomized run. Every cycle the outputs are
// compared with a behavioural model of the sequencer kept in this bench; the
// model tracks the run state, a remaining-drain count and the advanced-cycle
// count using plain integers. A narrow cycle counter is used so saturation is
// reached during the randomized run.
// -----------------------------------------------------------------------------
module tb_pipeline_sequencer;

  localparam int NS  = 5;
  localparam int SD  = 2;
  localparam int NCY = 5;
  localparam int CNT_MAX = (1 << NCY) - 1;

  // Model states, numbered as the sequencer reports them on o_state.
  localparam int M_IDLE = 0, M_RUN = 1, M_WAIT = 2, M_EXEC = 3, M_DRAIN = 4, M_DONE = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          i_reset, i_start, i_step_mode, i_step, i_halt;
  logic          i_halt_detected, i_hazard_stall, i_branch_flush, i_load_valid;
  logic [31:0]   i_load_addr, i_load_data;
  logic [NS-1:0] o_stage_enable, o_stage_flush;
  logic          o_imem_we;
  logic [31:0]   o_imem_addr, o_imem_data;
  logic [2:0]    o_state;
  logic [NCY-1:0] o_cycle_count;
  logic          o_done;

  pipeline_sequencer #(
    .NB_STAGES(NS), .NB_ADDR(32), .NB_DATA(32), .NB_CYCLES(NCY),
    .STALL_DEPTH(SD), .MAX_CYCLES(1000000)
  ) dut (
    .i_clk(clk), .i_reset(i_reset), .i_start(i_start), .i_step_mode(i_step_mode),
    .i_step(i_step), .i_halt(i_halt), .i_halt_detected(i_halt_detected),
    .i_hazard_stall(i_hazard_stall), .i_branch_flush(i_branch_flush),
    .i_load_valid(i_load_valid), .i_load_addr(i_load_addr), .i_load_data(i_load_data),
    .o_stage_enable(o_stage_enable), .o_stage_flush(o_stage_flush),
    .o_imem_we(o_imem_we), .o_imem_addr(o_imem_addr), .o_imem_data(o_imem_data),
    .o_state(o_state), .o_cycle_count(o_cycle_count), .o_done(o_done)
  );

  int tests  = 0;
  int errors = 0;

  int          m_state, m_cnt, m_drain;
  bit          m_done, m_we;
  logic [31:0] m_addr, m_data;

  task automatic checkEq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input bit rst, input bit start, input bit smode, input bit step,
                               input bit halt, input bit hd, input bit stall, input bit br,
                               input bit lv, input logic [31:0] la, input logic [31:0] ld);
    i_reset = rst; i_start = start; i_step_mode = smode; i_step = step; i_halt = halt;
    i_halt_detected = hd; i_hazard_stall = stall; i_branch_flush = br;
    i_load_valid = lv; i_load_addr = la; i_load_data = ld;
  endtask

  task automatic idleInputs();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
  endtask

  // Compare every output with the model as it stands before the next edge.
  task automatic checkOutput();
    logic [NS-1:0] exp_en, exp_fl;
    bit moving, draining;
    moving   = (m_state == M_RUN || m_state == M_EXEC || m_state == M_DRAIN) && !i_halt;
    draining = (m_state == M_DRAIN);
    for (int s = 0; s < NS; s++) begin
      exp_en[s] = moving && !(i_hazard_stall && s < SD) && !(draining && s == 0);
      exp_fl[s] = (moving && ((i_hazard_stall && s == SD) ||
                              (!i_hazard_stall && i_branch_flush && s == 1) ||
                              (draining && s == 1))) ||
                  (m_state == M_DONE && i_start && !i_halt);
    end
    checkEq("stage_enable", 64'(o_stage_enable), 64'(exp_en));
    checkEq("stage_flush", 64'(o_stage_flush), 64'(exp_fl));
    checkEq("state", 64'(o_state), 64'(m_state));
    checkEq("cycle_count", 64'(o_cycle_count), 64'(m_cnt));
    checkEq("done", 64'(o_done), 64'(m_done));
    checkEq("imem_we", 64'(o_imem_we), 64'(m_we));
    if (m_we) begin
      checkEq("imem_addr", 64'(o_imem_addr), 64'(m_addr));
      checkEq("imem_data", 64'(o_imem_data), 64'(m_data));
    end
  endtask

  // Advance the model by one clock using the inputs currently applied.
  task automatic stepModel();
    bit moving;
    if (i_reset) begin
      m_state = M_IDLE; m_cnt = 0; m_drain = 0; m_done = 0;
      m_we = 0; m_addr = '0; m_data = '0;
      return;
    end
    m_we = (m_state == M_IDLE) && i_load_valid;
    if (m_we) begin
      m_addr = i_load_addr;
      m_data = i_load_data;
    end
    if (i_halt) return;
    moving = (m_state == M_RUN || m_state == M_EXEC || m_state == M_DRAIN);
    if (moving && m_cnt < CNT_MAX) m_cnt++;
    if (m_state == M_IDLE) begin
      if (i_start) begin
        m_state = i_step_mode ? M_WAIT : M_RUN;
        m_cnt = 0;
      end
    end else if (m_state == M_RUN || m_state == M_EXEC) begin
      if (i_halt_detected && !i_hazard_stall) begin
        m_state = M_DRAIN;
        m_drain = NS - 1;
      end else if (m_state == M_EXEC) begin
        m_state = M_WAIT;
      end
    end else if (m_state == M_WAIT) begin
      if (i_step) m_state = M_EXEC;
    end else if (m_state == M_DRAIN) begin
      m_drain--;
      if (m_drain == 0) begin
        m_state = M_DONE;
        m_done = 1;
      end
    end else if (m_state == M_DONE) begin
      if (i_start) begin
        m_state = M_IDLE;
        m_done = 0;
      end
    end
  endtask

  // Called just after a falling edge with the inputs applied.
  task automatic cycle();
    #1;
    checkOutput();
    stepModel();
    @(negedge clk);
  endtask

  initial begin : main
    int full;
    idleInputs();
    i_reset = 1'b1;
    repeat (2) @(negedge clk);
    m_state = M_IDLE; m_cnt = 0; m_drain = 0; m_done = 0; m_we = 0; m_addr = '0; m_data = '0;
    cycle();
    idleInputs();
    #1;
    checkEq("reset_state", 64'(o_state), 64'd0);
    checkEq("reset_we", 64'(o_imem_we), 64'd0);
    cycle();

    // Program load of four words.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'(4 * i), $urandom);
      cycle();
    end
    idleInputs();
    cycle();

    // Free run, HALT at the tenth advanced cycle, then a four-cycle drain.
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 1, 32'h40, 32'hDEADBEEF);
    cycle();
    idleInputs();
    repeat (9) cycle();
    i_halt_detected = 1'b1;
    cycle();
    i_halt_detected = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      checkEq("drain_enable", 64'(o_stage_enable), 64'b11110);
      checkEq("drain_flush", 64'(o_stage_flush), 64'b00010);
      cycle();
    end
    #1;
    checkEq("done_state", 64'(o_state), 64'd5);
    checkEq("done_count", 64'(o_cycle_count), 64'd14);
    checkEq("done_flag", 64'(o_done), 64'd1);

    // Leave DONE, then stall and branch flush together.
    i_start = 1'b1;
    #1;
    checkEq("done_exit_flush", 64'(o_stage_flush), 64'b11111);
    cycle();
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
    cycle();
    idleInputs();
    i_hazard_stall = 1'b1; i_branch_flush = 1'b1; i_halt_detected = 1'b1;
    #1;
    checkEq("stall_enable", 64'(o_stage_enable), 64'b11100);
    checkEq("stall_flush", 64'(o_stage_flush), 64'b00100);
    cycle();
    idleInputs();
    #1;
    checkEq("stall_hd_ignored", 64'(o_state), 64'd1);
    cycle();
    i_halt_detected = 1'b1;
    cycle();
    idleInputs();
    repeat (4) cycle();
    i_start = 1'b1;
    cycle();

    // Single-step: three step pulses five cycles apart.
    applyStimulus(0, 1, 1, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
    cycle();
    idleInputs();
    full = 0;
    for (int i = 0; i < 15; i++) begin
      i_step = (i % 5 == 0);
      #1;
      if (o_stage_enable == 5'b11111) full++;
      cycle();
    end
    i_step = 1'b0;
    checkEq("step_full_cycles", 64'(full), 64'd3);
    #1;
    checkEq("step_count", 64'(o_cycle_count), 64'd3);

    // Halt during a step, freeze mid-drain with two drain cycles left.
    i_step = 1'b1;
    cycle();
    i_step = 1'b0; i_halt_detected = 1'b1;
    cycle();
    i_halt_detected = 1'b0;
    repeat (2) cycle();
    i_halt = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      checkEq("freeze_enable", 64'(o_stage_enable), 64'd0);
      checkEq("freeze_count", 64'(o_cycle_count), 64'd6);
      cycle();
    end
    i_halt = 1'b0;
    repeat (2) cycle();
    #1;
    checkEq("freeze_done", 64'(o_state), 64'd5);

    // Reset in the middle of a drain with a load request present.
    i_start = 1'b1;
    cycle();
    i_start = 1'b1;
    cycle();
    i_start = 1'b0; i_halt_detected = 1'b1;
    cycle();
    i_halt_detected = 1'b0;
    cycle();
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 1, 32'h80, 32'h12345678);
    cycle();
    idleInputs();
    #1;
    checkEq("rst_state", 64'(o_state), 64'd0);
    checkEq("rst_count", 64'(o_cycle_count), 64'd0);
    checkEq("rst_we", 64'(o_imem_we), 64'd0);
    checkEq("rst_enable", 64'(o_stage_enable), 64'd0);
    cycle();

    // Randomized traffic against the model.
    for (int i = 0; i < 800; i++) begin
      applyStimulus(($urandom_range(0, 79) == 0), ($urandom_range(0, 5) == 0),
                    1'($urandom), ($urandom_range(0, 2) == 0),
                    ($urandom_range(0, 5) == 0), ($urandom_range(0, 11) == 0),
                    ($urandom_range(0, 4) == 0), ($urandom_range(0, 4) == 0),
                    ($urandom_range(0, 2) == 0), $urandom, $urandom);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
